in_conditioner: RTL and testbench

- Input conditioning stage directly upstream of the 3-input AND/OR reduction block.
- Takes N_CH raw, asynchronous, bouncy inputs (switches/buttons) and synchronises each one into the clock domain.
- Debounces each channel independently and presents clean, registered levels that drive the reduction block's in_1..in_3.
- Also provides a "no channel in transition" status bit.

---
 rtl/in_conditioner.sv | 163 ++++++++++++++++
 tb/tb_in_conditioner.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/in_conditioner.sv
// Input conditioner: per-channel synchroniser plus 4-state debounce FSM feeding the AND/OR reduction block.
// Optional registered rise/fall pulses are built only when IN_COND_EDGE_EN is defined.
module in_conditioner #(
    parameter int N_CH        = 3,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] raw_i,
    output logic [N_CH-1:0] clean_o,
    output logic            settled_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o
);
    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_LO     = 2'd0,
        ST_CHK_HI = 2'd1,
        ST_HI     = 2'd2,
        ST_CHK_LO = 2'd3
    } state_t;

    logic [N_CH-1:0][SYNC_STAGES-1:0] sync_r;
    state_t [N_CH-1:0]                state_r;
    logic [N_CH-1:0][CNT_W-1:0]       cnt_r;
    logic [N_CH-1:0]                  clean_r;
    logic                             settled_r;
    logic [N_CH-1:0]                  samp_s;
    logic [N_CH-1:0]                  pend_s;

    // Synchroniser chains: plain flop-to-flop shift, new sample enters at bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                sync_r[k] <= {sync_r[k][SYNC_STAGES-2:0], raw_i[k]};
            end
        end
    end

    // Synchronised sample and "still pending after this edge" per channel.
    always_comb begin
        samp_s = '0;
        pend_s = '0;
        for (int k = 0; k < N_CH; k++) begin
            samp_s[k] = sync_r[k][SYNC_STAGES-1];
            // Disagreeing sample leaves the channel in a check state unless this is the accepting sample.
            pend_s[k] = (samp_s[k] != clean_r[k]) && (cnt_r[k] != CNT_LAST);
        end
    end

    // Debounce FSM per channel, plus the registered settled status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CH; k++) begin
                state_r[k] <= ST_LO;
                cnt_r[k]   <= '0;
            end
            clean_r   <= '0;
            settled_r <= 1'b1;
        end else begin
            settled_r <= ~|pend_s;
            for (int k = 0; k < N_CH; k++) begin
                case (state_r[k])
                    ST_LO: begin
                        if (samp_s[k]) begin
                            if (DB_CYCLES == 1) begin
                                state_r[k] <= ST_HI;
                                clean_r[k] <= 1'b1;
                            end else begin
                                state_r[k] <= ST_CHK_HI;
                                cnt_r[k]   <= CNT_ONE;
                            end
                        end
                    end
                    ST_CHK_HI: begin
                        if (!samp_s[k]) begin
                            state_r[k] <= ST_LO;
                            cnt_r[k]   <= '0;
                        end else if (cnt_r[k] == CNT_LAST) begin
                            state_r[k] <= ST_HI;
                            clean_r[k] <= 1'b1;
                            cnt_r[k]   <= '0;
                        end else begin
                            cnt_r[k] <= cnt_r[k] + CNT_ONE;
                        end
                    end
                    ST_HI: begin
                        if (!samp_s[k]) begin
                            if (DB_CYCLES == 1) begin
                                state_r[k] <= ST_LO;
                                clean_r[k] <= 1'b0;
                            end else begin
                                state_r[k] <= ST_CHK_LO;
                                cnt_r[k]   <= CNT_ONE;
                            end
                        end
                    end
                    ST_CHK_LO: begin
                        if (samp_s[k]) begin
                            state_r[k] <= ST_HI;
                            cnt_r[k]   <= '0;
                        end else if (cnt_r[k] == CNT_LAST) begin
                            state_r[k] <= ST_LO;
                            clean_r[k] <= 1'b0;
                            cnt_r[k]   <= '0;
                        end else begin
                            cnt_r[k] <= cnt_r[k] + CNT_ONE;
                        end
                    end
                    default: begin
                        state_r[k] <= ST_LO;
                        clean_r[k] <= 1'b0;
                        cnt_r[k]   <= '0;
                    end
                endcase
            end
        end
    end

    assign clean_o   = clean_r;
    assign settled_o = settled_r;

`ifdef IN_COND_EDGE_EN
    logic [N_CH-1:0] go_hi_s;
    logic [N_CH-1:0] go_lo_s;
    logic [N_CH-1:0] rise_r;
    logic [N_CH-1:0] fall_r;

    // A level flips exactly when the accepting sample agrees with the new level.
    always_comb begin
        go_hi_s = '0;
        go_lo_s = '0;
        for (int k = 0; k < N_CH; k++) begin
            go_hi_s[k] = !clean_r[k] && samp_s[k]  && (cnt_r[k] == CNT_LAST);
            go_lo_s[k] = clean_r[k]  && !samp_s[k] && (cnt_r[k] == CNT_LAST);
        end
    end

    // Edge pulses registered alongside clean_r so they line up with the level change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_r <= '0;
            fall_r <= '0;
        end else begin
            rise_r <= go_hi_s;
            fall_r <= go_lo_s;
        end
    end

    assign rise_o = rise_r;
    assign fall_o = fall_r;
`else
    assign rise_o = '0;
    assign fall_o = '0;
`endif

endmodule

// File: tb/tb_in_conditioner.sv
// Bench for in_conditioner: window-of-samples reference model checked every cycle, plus directed literals.
module tb_in_conditioner;
    localparam int SYNC = 2;
    localparam int DB_A = 4;
    localparam int DB_B = 1;
`ifdef IN_COND_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] raw_a, raw_b;
    logic [2:0] clean_a, rise_a, fall_a;
    logic [2:0] clean_b, rise_b, fall_b;
    logic       settled_a, settled_b;
    int         checks = 0;
    int         errors = 0;
    logic       cmp_en = 1'b0;

    always #5 clk = ~clk;

    in_conditioner #(.N_CH(3), .SYNC_STAGES(SYNC), .DB_CYCLES(DB_A)) dut (
        .clk(clk), .rst_n(rst_n), .raw_i(raw_a), .clean_o(clean_a),
        .settled_o(settled_a), .rise_o(rise_a), .fall_o(fall_a)
    );

    in_conditioner #(.N_CH(3), .SYNC_STAGES(SYNC), .DB_CYCLES(DB_B)) dut1 (
        .clk(clk), .rst_n(rst_n), .raw_i(raw_b), .clean_o(clean_b),
        .settled_o(settled_b), .rise_o(rise_b), .fall_o(fall_b)
    );

    // Model: raw sample history per channel (bit 0 = most recent edge). The sample seen
    // by the debouncer at an edge is the raw value from SYNC edges earlier. A new level is
    // accepted once the last db such samples all agree on it.
    logic [15:0] hist_a [3];
    logic [15:0] hist_b [3];
    logic [2:0]  m_clean_a, m_rise_a, m_fall_a, m_clean_b, m_rise_b, m_fall_b;
    logic        m_settled_a, m_settled_b;

    function automatic logic accept(input logic [15:0] h, input logic cur, input int db);
        logic [15:0] mask;
        logic [15:0] w;
        mask = (16'd1 << db) - 16'd1;
        w    = (h >> (SYNC - 1)) & mask;
        if (w == mask) return 1'b1;
        else if (w == 16'd0) return 1'b0;
        else return cur;
    endfunction

    function automatic logic quiet(input logic [15:0] h, input logic cur, input int db);
        logic s_now;
        s_now = h[SYNC-1];
        return s_now == accept(h, cur, db);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                hist_a[k] <= 16'd0;
                hist_b[k] <= 16'd0;
            end
            m_clean_a <= 3'b000; m_rise_a <= 3'b000; m_fall_a <= 3'b000; m_settled_a <= 1'b1;
            m_clean_b <= 3'b000; m_rise_b <= 3'b000; m_fall_b <= 3'b000; m_settled_b <= 1'b1;
        end else begin
            for (int k = 0; k < 3; k++) begin
                hist_a[k]   <= {hist_a[k][14:0], raw_a[k]};
                hist_b[k]   <= {hist_b[k][14:0], raw_b[k]};
                m_clean_a[k] <= accept(hist_a[k], m_clean_a[k], DB_A);
                m_rise_a[k]  <= accept(hist_a[k], m_clean_a[k], DB_A) & ~m_clean_a[k];
                m_fall_a[k]  <= ~accept(hist_a[k], m_clean_a[k], DB_A) & m_clean_a[k];
                m_clean_b[k] <= accept(hist_b[k], m_clean_b[k], DB_B);
                m_rise_b[k]  <= accept(hist_b[k], m_clean_b[k], DB_B) & ~m_clean_b[k];
                m_fall_b[k]  <= ~accept(hist_b[k], m_clean_b[k], DB_B) & m_clean_b[k];
            end
            m_settled_a <= quiet(hist_a[0], m_clean_a[0], DB_A) & quiet(hist_a[1], m_clean_a[1], DB_A)
                         & quiet(hist_a[2], m_clean_a[2], DB_A);
            m_settled_b <= quiet(hist_b[0], m_clean_b[0], DB_B) & quiet(hist_b[1], m_clean_b[1], DB_B)
                         & quiet(hist_b[2], m_clean_b[2], DB_B);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_clean_a",   {29'd0, clean_a},   {29'd0, m_clean_a});
            check("model_settled_a", {31'd0, settled_a}, {31'd0, m_settled_a});
            check("model_rise_a",    {29'd0, rise_a},    EDGE_EN ? {29'd0, m_rise_a} : 32'd0);
            check("model_fall_a",    {29'd0, fall_a},    EDGE_EN ? {29'd0, m_fall_a} : 32'd0);
            check("model_clean_b",   {29'd0, clean_b},   {29'd0, m_clean_b});
            check("model_settled_b", {31'd0, settled_b}, {31'd0, m_settled_b});
            check("model_rise_b",    {29'd0, rise_b},    EDGE_EN ? {29'd0, m_rise_b} : 32'd0);
            check("model_fall_b",    {29'd0, fall_b},    EDGE_EN ? {29'd0, m_fall_b} : 32'd0);
        end
    end

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [7:0] pat;

    initial begin
        rst_n = 1'b0;
        raw_a = 3'b111;
        raw_b = 3'b111;
        adv(3);
        cmp_en = 1'b1;
        // Reset value with all inputs high
        check("rst_clean_a",   {29'd0, clean_a},   32'd0);
        check("rst_settled_a", {31'd0, settled_a}, 32'd1);
        check("rst_clean_b",   {29'd0, clean_b},   32'd0);
        rst_n = 1'b1;
        adv(2);
        check("rel_e1_settled", {31'd0, settled_a}, 32'd1);
        adv(1);
        check("rel_e2_settled", {31'd0, settled_a}, 32'd0);
        check("rel_e2_clean_b", {29'd0, clean_b},   32'h7);
        adv(2);
        check("rel_e4_clean",   {29'd0, clean_a},   32'd0);
        check("rel_e4_settled", {31'd0, settled_a}, 32'd0);
        adv(1);
        check("rel_e5_clean",   {29'd0, clean_a},   32'h7);
        check("rel_e5_settled", {31'd0, settled_a}, 32'd1);
        check("rel_e5_rise",    {29'd0, rise_a},    EDGE_EN ? 32'h7 : 32'd0);

        // Fall: DB_CYCLES=1 instance drops ch2, main instance drops everything
        raw_b = 3'b011;
        raw_a = 3'b000;
        adv(2);
        check("db1_e1_clean", {29'd0, clean_b}, 32'h7);
        adv(1);
        check("db1_e2_clean",   {29'd0, clean_b},   32'h3);
        check("db1_e2_settled", {31'd0, settled_b}, 32'd1);
        check("db1_e2_fall",    {29'd0, fall_b},    EDGE_EN ? 32'h4 : 32'd0);
        adv(2);
        check("fall_e4_clean", {29'd0, clean_a}, 32'h7);
        adv(1);
        check("fall_e5_clean", {29'd0, clean_a}, 32'd0);
        check("fall_e5_fall",  {29'd0, fall_a},  EDGE_EN ? 32'h7 : 32'd0);
        adv(3);

        // Clean rise on channel 0
        raw_a = 3'b001;
        adv(5);
        check("rise0_e4_clean", {29'd0, clean_a}, 32'd0);
        adv(1);
        check("rise0_e5_clean", {29'd0, clean_a}, 32'h1);
        check("rise0_e5_pulse", {29'd0, rise_a},  EDGE_EN ? 32'h1 : 32'd0);
        adv(1);
        check("rise0_e6_pulse", {29'd0, rise_a},  32'd0);
        raw_a = 3'b000;
        adv(8);

        // Bounce rejection on channel 1: samples 1,1,1,0,1,1,1,1
        pat = 8'b1111_0111;
        for (int i = 0; i < 8; i++) begin
            raw_a[1] = pat[i];
            adv(1);
        end
        adv(1);
        check("bounce_e8_clean", {29'd0, clean_a}, 32'd0);
        adv(1);
        check("bounce_e9_clean", {29'd0, clean_a}, 32'h2);
        raw_a = 3'b000;
        adv(8);

        // Independent channels: ch0 at edge 0, ch2 at edge 2
        raw_a = 3'b001;
        adv(2);
        raw_a = 3'b101;
        adv(4);
        check("indep_e5_clean",   {29'd0, clean_a},   32'h1);
        check("indep_e5_settled", {31'd0, settled_a}, 32'd0);
        adv(1);
        check("indep_e6_settled", {31'd0, settled_a}, 32'd0);
        adv(1);
        check("indep_e7_clean",   {29'd0, clean_a},   32'h5);
        check("indep_e7_settled", {31'd0, settled_a}, 32'd1);
        raw_a = 3'b000;
        adv(8);

        // Reset mid-check on channel 0
        raw_a = 3'b001;
        adv(3);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_clean",   {29'd0, clean_a},   32'd0);
        check("midrst_settled", {31'd0, settled_a}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        adv(5);
        check("midrst_e4_clean", {29'd0, clean_a}, 32'd0);
        adv(1);
        check("midrst_e5_clean", {29'd0, clean_a}, 32'h1);
        check("midrst_e5_rise",  {29'd0, rise_a},  EDGE_EN ? 32'h1 : 32'd0);
        adv(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
